// File: rtl/neuron_tick_scheduler_pkg.sv
// Shared types and constants for the neuron tick scheduler: SRAM entry layout,
// spike packet layout, sequencer states and saturating arithmetic helpers.
package neuron_tick_scheduler_pkg;

  localparam int N_COUNT        = 256;
  localparam int V_PRECISION    = 4;
  localparam int PKT_SIZE       = 32;
  localparam int SRAM_ADDR_SIZE = $clog2(N_COUNT);

  typedef struct packed {
    logic [N_COUNT-1:0]     connections;
    logic [V_PRECISION-1:0] membrane_potential;
    logic [V_PRECISION-1:0] vthresh;
    logic [V_PRECISION-1:0] a;
    logic [V_PRECISION-1:0] b;
    logic [V_PRECISION-1:0] c;
  } sram_data_t;

  typedef struct packed {
    logic [15:0] tick;
    logic [7:0]  core;
    logic [7:0]  nrn;
  } spike_pkt_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_RD   = 3'd1,
    ST_UPD  = 3'd2,
    ST_EMIT = 3'd3,
    ST_DONE = 3'd4
  } sched_state_e;

  // Clamps to all-ones instead of wrapping.
  function automatic logic [V_PRECISION-1:0] sat_add(input logic [V_PRECISION-1:0] x,
                                                     input logic [V_PRECISION-1:0] y);
    logic [V_PRECISION:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    return sum[V_PRECISION] ? {V_PRECISION{1'b1}} : sum[V_PRECISION-1:0];
  endfunction

  // Clamps to zero instead of wrapping.
  function automatic logic [V_PRECISION-1:0] sat_sub(input logic [V_PRECISION-1:0] x,
                                                     input logic [V_PRECISION-1:0] y);
    return (x > y) ? (x - y) : {V_PRECISION{1'b0}};
  endfunction

endpackage

// File: rtl/neuron_tick_scheduler_update.sv
// Combinational neuron step: integrate on an axon hit, leak, threshold and
// pick the potential to write back.
module neuron_update
  import neuron_tick_scheduler_pkg::*;
(
  input  sram_data_t             rdata,
  input  logic [N_COUNT-1:0]     axon_q,
  output logic [V_PRECISION-1:0] v_next,
  output logic                   fire
);

  logic                   hit_s;
  logic [V_PRECISION-1:0] vi_s;
  logic [V_PRECISION-1:0] vl_s;

  // Integrate, leak, then threshold against vthresh.
  always_comb begin
    hit_s = |(rdata.connections & axon_q);
    if (hit_s) begin
      vi_s = sat_add(rdata.membrane_potential, rdata.a);
    end else begin
      vi_s = rdata.membrane_potential;
    end
    vl_s = sat_sub(vi_s, rdata.b);
    fire = (vl_s >= rdata.vthresh);
    if (fire) begin
      v_next = rdata.c;
    end else begin
      v_next = vl_s;
    end
  end

endmodule

// File: rtl/neuron_tick_scheduler.sv
// Per-tick sequencer: walks every neuron through read, update and write-back,
// and emits a spike packet for each neuron that fires.
module neuron_tick_scheduler
  import neuron_tick_scheduler_pkg::*;
#(
  parameter logic [7:0] CORE_ID = 8'h00
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      tick,
  input  logic [N_COUNT-1:0]        axon_in,
  output logic                      sram_re,
  output logic [SRAM_ADDR_SIZE-1:0] sram_addr,
  input  sram_data_t                sram_rdata,
  output logic                      sram_we,
  output sram_data_t                sram_wdata,
  output logic                      pkt_valid,
  output logic [PKT_SIZE-1:0]       pkt_data,
  input  logic                      pkt_ready,
  output logic                      busy,
  output logic                      pass_done,
  output logic                      tick_overrun
);

  localparam logic [SRAM_ADDR_SIZE-1:0] LAST_IDX = SRAM_ADDR_SIZE'(N_COUNT - 1);
  localparam logic [SRAM_ADDR_SIZE-1:0] IDX_ONE  = SRAM_ADDR_SIZE'(1);

  sched_state_e              state_r, state_nxt_s;
  logic [SRAM_ADDR_SIZE-1:0] idx_r, idx_nxt_s;
  logic [N_COUNT-1:0]        axon_q_r;
  logic [15:0]               tick_cnt_r;
  logic [PKT_SIZE-1:0]       pkt_data_r;
  logic                      load_axon_s, load_pkt_s, last_s;
  logic [V_PRECISION-1:0]    v_next_s;
  logic                      fire_s;
  spike_pkt_t                pkt_nxt_s;
  logic                      sram_re_r, sram_we_r, pkt_valid_r, busy_r, pass_done_r, tick_overrun_r;
  logic [SRAM_ADDR_SIZE-1:0] sram_addr_r;

  neuron_update u_update (
    .rdata  (sram_rdata),
    .axon_q (axon_q_r),
    .v_next (v_next_s),
    .fire   (fire_s)
  );

  // Next-state and index sequencing.
  always_comb begin
    state_nxt_s = state_r;
    idx_nxt_s   = idx_r;
    load_axon_s = 1'b0;
    load_pkt_s  = 1'b0;
    last_s      = (idx_r == LAST_IDX);
    case (state_r)
      ST_IDLE: begin
        if (tick) begin
          state_nxt_s = ST_RD;
          idx_nxt_s   = {SRAM_ADDR_SIZE{1'b0}};
          load_axon_s = 1'b1;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RD:   state_nxt_s = ST_UPD;
      ST_UPD: begin
        if (fire_s) begin
          state_nxt_s = ST_EMIT;
          load_pkt_s  = 1'b1;
        end else if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RD;
          idx_nxt_s   = idx_r + IDX_ONE;
        end
      end
      ST_EMIT: begin
        if (!pkt_ready) begin
          state_nxt_s = ST_EMIT;
        end else if (last_s) begin
          state_nxt_s = ST_DONE;
        end else begin
          state_nxt_s = ST_RD;
          idx_nxt_s   = idx_r + IDX_ONE;
        end
      end
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Packet fields and write-back data; wdata follows rdata because it is only valid in UPD.
  always_comb begin
    pkt_nxt_s.tick = tick_cnt_r;
    pkt_nxt_s.core = CORE_ID;
    pkt_nxt_s.nrn  = 8'(idx_r);
    if (state_r == ST_UPD) begin
      sram_wdata                    = sram_rdata;
      sram_wdata.membrane_potential = v_next_s;
    end else begin
      sram_wdata = '0;
    end
  end

  // State, counters and registered outputs aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r        <= ST_IDLE;
      idx_r          <= {SRAM_ADDR_SIZE{1'b0}};
      axon_q_r       <= {N_COUNT{1'b0}};
      tick_cnt_r     <= 16'd0;
      pkt_data_r     <= {PKT_SIZE{1'b0}};
      sram_re_r      <= 1'b0;
      sram_we_r      <= 1'b0;
      sram_addr_r    <= {SRAM_ADDR_SIZE{1'b0}};
      pkt_valid_r    <= 1'b0;
      busy_r         <= 1'b0;
      pass_done_r    <= 1'b0;
      tick_overrun_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      idx_r   <= idx_nxt_s;
      if (load_axon_s) axon_q_r <= axon_in;
      if (load_pkt_s) pkt_data_r <= pkt_nxt_s;
      if (state_r == ST_DONE) tick_cnt_r <= tick_cnt_r + 16'd1;
      sram_re_r   <= (state_nxt_s == ST_RD);
      sram_we_r   <= (state_nxt_s == ST_UPD);
      sram_addr_r <= ((state_nxt_s == ST_RD) || (state_nxt_s == ST_UPD)) ? idx_nxt_s
                                                                         : {SRAM_ADDR_SIZE{1'b0}};
      pkt_valid_r    <= (state_nxt_s == ST_EMIT);
      busy_r         <= (state_nxt_s != ST_IDLE);
      pass_done_r    <= (state_nxt_s == ST_DONE);
      tick_overrun_r <= tick && (state_r != ST_IDLE);
    end
  end

  assign sram_re      = sram_re_r;
  assign sram_we      = sram_we_r;
  assign sram_addr    = sram_addr_r;
  assign pkt_valid    = pkt_valid_r;
  assign pkt_data     = pkt_data_r;
  assign busy         = busy_r;
  assign pass_done    = pass_done_r;
  assign tick_overrun = tick_overrun_r;

endmodule

// File: tb/tb_neuron_tick_scheduler.sv
// Self-checking bench: SRAM model, pass-level reference model and a per-cycle compare monitor.
module tb_neuron_tick_scheduler;
  import neuron_tick_scheduler_pkg::*;

  logic clk = 1'b0;
  logic rst, tick, pkt_ready;
  logic [N_COUNT-1:0] axon_in;
  logic sram_re, sram_we, pkt_valid, busy, pass_done, tick_overrun;
  logic [SRAM_ADDR_SIZE-1:0] sram_addr;
  logic [PKT_SIZE-1:0] pkt_data;
  sram_data_t sram_rdata, sram_wdata;

  neuron_tick_scheduler #(.CORE_ID(8'h00)) dut (
    .clk(clk), .rst(rst), .tick(tick), .axon_in(axon_in),
    .sram_re(sram_re), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .sram_we(sram_we), .sram_wdata(sram_wdata),
    .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_ready(pkt_ready),
    .busy(busy), .pass_done(pass_done), .tick_overrun(tick_overrun)
  );

  always #5 clk = ~clk;

  // SRAM model with a bench-side load port.
  sram_data_t mem [N_COUNT];
  logic tb_we = 1'b0;
  logic [7:0] tb_addr = 8'd0;
  sram_data_t tb_wdata;
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_wdata;
    else if (sram_we) mem[sram_addr] <= sram_wdata;
    if (sram_re) sram_rdata <= mem[sram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0, n_bad = 0;
  int model_tick_cnt = 0, tick_cyc = 0, n_ovr = 0, ready_mode = 0;
  int exp_addr_q[$];
  sram_data_t exp_data_q[$];
  logic [31:0] exp_pkt_q[$];
  logic [3:0] cap_pot [N_COUNT];
  logic [31:0] cap_pkt;
  sram_data_t img [N_COUNT];

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name, input string got, input string req);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: got %s, required %s", name, got, req);
  endtask

  // Neuron rule in plain integer arithmetic.
  function automatic sram_data_t model_neuron(input sram_data_t e, input logic [N_COUNT-1:0] ax,
                                              output bit fired);
    int vi, vl, vmax;
    sram_data_t r;
    vmax = (1 << V_PRECISION) - 1;
    vi = int'(e.membrane_potential);
    if ((e.connections & ax) != '0) vi = vi + int'(e.a);
    if (vi > vmax) vi = vmax;
    vl = vi - int'(e.b);
    if (vl < 0) vl = 0;
    fired = (vl >= int'(e.vthresh));
    r = e;
    r.membrane_potential = fired ? e.c : 4'(vl);
    return r;
  endfunction

  task automatic plan_pass();
    bit f;
    sram_data_t e;
    for (int i = 0; i < N_COUNT; i++) begin
      e = model_neuron(mem[i], axon_in, f);
      exp_addr_q.push_back(i);
      exp_data_q.push_back(e);
      if (f) exp_pkt_q.push_back({model_tick_cnt[15:0], 8'h00, i[7:0]});
    end
  endtask

  task automatic clear_model();
    exp_addr_q.delete();
    exp_data_q.delete();
    exp_pkt_q.delete();
    model_tick_cnt = 0;
  endtask

  // Compare process: every cycle outside reset.
  initial begin
    bit ovr_pending, prev_hold;
    logic [31:0] prev_pkt;
    ovr_pending = 1'b0;
    prev_hold = 1'b0;
    prev_pkt = 32'd0;
    forever begin
      @(negedge clk);
      if (rst) begin
        ovr_pending = 1'b0;
        prev_hold = 1'b0;
      end else begin
        check("tick_overrun", tick_overrun, ovr_pending);
        if (tick_overrun) n_ovr++;
        if (prev_hold) begin
          check("pkt_hold", {pkt_valid, pkt_data}, {1'b1, prev_pkt});
          check("stall_quiet", {sram_re, sram_we}, 2'b00);
        end
        if (sram_re) begin
          if (exp_addr_q.size() == 0) flag("unexpected_read", $sformatf("read %0d", sram_addr), "none");
          else check("rd_addr", sram_addr, exp_addr_q[0]);
        end
        if (sram_we) begin
          if (exp_addr_q.size() == 0) flag("unexpected_write", $sformatf("write %0d", sram_addr), "none");
          else begin
            check("wr_addr", sram_addr, exp_addr_q.pop_front());
            check("wr_data", sram_wdata, exp_data_q.pop_front());
          end
          cap_pot[sram_addr] = sram_wdata.membrane_potential;
        end
        if (pkt_valid && pkt_ready) begin
          if (exp_pkt_q.size() == 0) flag("unexpected_pkt", $sformatf("%08h", pkt_data), "none");
          else check("pkt", pkt_data, exp_pkt_q.pop_front());
          cap_pkt = pkt_data;
        end
        if (pass_done) check("done_drained", exp_addr_q.size() + exp_pkt_q.size(), 0);
        ovr_pending = tick && busy;
        prev_hold = pkt_valid && !pkt_ready;
        prev_pkt = pkt_data;
      end
    end
  end

  // pkt_ready driver: 0 always ready, 1 random, 2 held low.
  initial begin
    pkt_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: pkt_ready = 1'b1;
        1: pkt_ready = 1'($urandom_range(0, 1));
        default: pkt_ready = 1'b0;
      endcase
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_base();
    for (int i = 0; i < N_COUNT; i++)
      img[i] = '{connections: '0, membrane_potential: 4'd0, vthresh: 4'd15, a: 4'd3, b: 4'd1, c: 4'd0};
  endtask

  task automatic load_img();
    for (int i = 0; i < N_COUNT; i++) begin
      step();
      tb_we = 1'b1;
      tb_addr = i[7:0];
      tb_wdata = img[i];
    end
    step();
    tb_we = 1'b0;
  endtask

  task automatic rand_axons();
    for (int j = 0; j < N_COUNT / 32; j++) axon_in[j*32 +: 32] = $urandom;
  endtask

  task automatic start_pass();
    step();
    plan_pass();
    tick = 1'b1;
    tick_cyc = cyc;
    step();
    tick = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    bit got;
    got = 1'b0;
    dcyc = -1;
    for (int k = 0; k < 5000 && !got; k++) begin
      @(negedge clk);
      if (pass_done) begin
        got = 1'b1;
        dcyc = cyc - tick_cyc;
      end
    end
    if (!got) flag("pass_timeout", "no pass_done", "pass_done within 5000 cycles");
    model_tick_cnt++;
  endtask

  task automatic wait_event(input string name, input bit want_valid, input int addr);
    bit got;
    got = 1'b0;
    for (int k = 0; k < 2000 && !got; k++) begin
      @(negedge clk);
      if (want_valid ? pkt_valid : (sram_re && sram_addr == 8'(addr))) got = 1'b1;
    end
    if (!got) flag(name, "no event", "event within 2000 cycles");
  endtask

  task automatic pulse_rst();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
  endtask

  initial begin
    int d, ovr0;
    rst = 1'b1; tick = 1'b0; axon_in = '0; tb_wdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {sram_re, sram_we, sram_addr, sram_wdata, pkt_valid, pkt_data,
                            busy, pass_done, tick_overrun}, '0);
    step();
    rst = 1'b0;
    clear_model();

    // Tests 1 and 2: uniform neurons, no axons.
    fill_base();
    load_img();
    start_pass();
    @(negedge clk);
    check("first_read", {sram_re, sram_addr, busy}, {1'b1, 8'd0, 1'b1});
    wait_done(d);
    check("pass_len_min", d, 513);
    check("uniform_pot_0", cap_pot[0], 4'd0);

    // Test 3: neuron 5 fires on axon 7.
    pulse_rst();
    fill_base();
    img[5].connections[7] = 1'b1;
    img[5].a = 4'd4; img[5].b = 4'd1; img[5].vthresh = 4'd3; img[5].c = 4'd2;
    load_img();
    axon_in = '0;
    axon_in[7] = 1'b1;
    start_pass();
    wait_done(d);
    check("t3_pkt", cap_pkt, 32'h0000_0005);
    check("t3_pot5", cap_pot[5], 4'd2);
    check("t3_len", d, 514);

    // Test 4: same with a 20-cycle downstream stall.
    ready_mode = 2;
    load_img();
    start_pass();
    wait_event("t4_valid_seen", 1'b1, 0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check("t4_stall", {pkt_valid, pkt_data, sram_re, sram_we}, {1'b1, 32'h0001_0005, 2'b00});
    end
    ready_mode = 0;
    wait_event("t4_resume6", 1'b0, 6);
    wait_done(d);

    // Test 5: saturating integrate and saturating leak.
    fill_base();
    img[0] = '{connections: '0, membrane_potential: 4'd14, vthresh: 4'd15, a: 4'd5, b: 4'd0, c: 4'd3};
    img[0].connections[0] = 1'b1;
    img[1] = '{connections: '0, membrane_potential: 4'd9, vthresh: 4'd15, a: 4'd5, b: 4'd15, c: 4'd3};
    load_img();
    axon_in = '0;
    axon_in[0] = 1'b1;
    start_pass();
    wait_done(d);
    check("t5_sat_fire", cap_pot[0], 4'd3);
    check("t5_leak_floor", cap_pot[1], 4'd0);
    check("t5_pkt", cap_pkt, 32'h0002_0000);

    // Test 6: tick while busy, then reset mid-pass at neuron 100.
    fill_base();
    load_img();
    start_pass();
    repeat (50) step();
    ovr0 = n_ovr;
    tick = 1'b1;
    rand_axons();
    step();
    tick = 1'b0;
    repeat (3) step();
    check("t6_overrun_count", n_ovr - ovr0, 1);
    begin
      bit got;
      got = 1'b0;
      for (int k = 0; k < 1000 && !got; k++) begin
        step();
        if (sram_re && sram_addr == 8'd100) got = 1'b1;
      end
      if (!got) flag("t6_reach100", "not reached", "read of neuron 100");
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_model();
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("t6_after_rst", {busy, sram_we, sram_re}, 3'b000);
    end

    // Randomized passes with random backpressure and ticks injected while busy.
    ready_mode = 1;
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < N_COUNT; i++) begin
        for (int j = 0; j < N_COUNT / 32; j++) img[i].connections[j*32 +: 32] = $urandom;
        img[i].membrane_potential = 4'($urandom);
        img[i].vthresh = 4'($urandom);
        img[i].a = 4'($urandom);
        img[i].b = 4'($urandom_range(0, 3));
        img[i].c = 4'($urandom);
      end
      load_img();
      rand_axons();
      start_pass();
      fork
        wait_done(d);
        begin
          int dl;
          dl = $urandom_range(2, 700);
          repeat (dl) step();
          if (busy) begin
            tick = 1'b1;
            rand_axons();
            step();
            tick = 1'b0;
          end
        end
      join
    end

    repeat (5) step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
